fp_norm_stage: RTL and testbench

Two-stage pipelined post-add normalizer for the single-precision adder/subtractor datapath. It consumes the raw 25-bit magnitude sum, with carry-out in bit 24, from the add/sub stage. It locates the leading one with the existing 24-bit leading-one detector, then left-shifts or right-shifts the mantissa and adjusts the biased exponent. It also flags zero, underflow (denormal result) and overflow, and feeds the rounding stage through a valid/ready handshake with full backpressure.

---
 rtl/fp_norm_pkg.sv | 32 +++
 rtl/fp_norm_stage_if.sv | 37 +++
 rtl/LOPD_24bit.sv | 20 ++
 rtl/fp_norm_stage.sv | 125 ++++++++++++
 tb/tb_fp_norm_stage.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_norm_pkg.sv
// Shared widths and pipeline payload types for the post-add normalizer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fp_norm_pkg;

  localparam int EXP_W  = 8;
  localparam int MANT_W = 24;
  localparam int SH_W   = 5;

  localparam logic [EXP_W-1:0] EXP_INF = 8'hFF;

  // Stage-1 register contents: raw operand plus leading-one information.
  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W:0]   mant;
    logic [SH_W-1:0]   pos;
    logic              zero;
  } norm_s1_t;

  // Stage-2 (output) register contents handed to the rounder.
  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
    logic              sticky;
    logic              zero;
    logic              underflow;
    logic              overflow;
  } norm_out_t;

endpackage

// File: rtl/fp_norm_stage_if.sv
// Upstream request and downstream result channel of the normalizer.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both sides; o_ready may depend on i_ready.
interface fp_norm_stage_if;
  import fp_norm_pkg::*;

  logic              i_valid;
  logic              o_ready;
  logic              i_sign;
  logic [EXP_W-1:0]  i_exp;
  logic [MANT_W:0]   i_mant;

  logic              o_valid;
  logic              i_ready;
  logic              o_sign;
  logic [EXP_W-1:0]  o_exp;
  logic [MANT_W-1:0] o_mant;
  logic              o_sticky;
  logic              o_zero;
  logic              o_underflow;
  logic              o_overflow;

  // Seen from the normalizer.
  modport slave (
    input  i_valid, i_sign, i_exp, i_mant, i_ready,
    output o_ready, o_valid, o_sign, o_exp, o_mant,
           o_sticky, o_zero, o_underflow, o_overflow
  );

  // Seen from the environment driving and consuming the normalizer.
  modport master (
    output i_valid, i_sign, i_exp, i_mant, i_ready,
    input  o_ready, o_valid, o_sign, o_exp, o_mant,
           o_sticky, o_zero, o_underflow, o_overflow
  );

endinterface

// File: rtl/LOPD_24bit.sv
// Leading-one position detector over a 24-bit word.
// Latency: combinational.
// Backpressure: none.
module LOPD_24bit (
  input  logic [23:0] i_data,
  output logic [4:0]  o_pos,
  output logic        o_zero
);

  // Highest set bit wins because later iterations overwrite earlier ones.
  always_comb begin
    o_pos = 5'd0;
    for (int i = 0; i < 24; i++) begin
      if (i_data[i]) o_pos = 5'(i);
    end
  end

  assign o_zero = ~|i_data;

endmodule

// File: rtl/fp_norm_stage.sv
// Post-add normalizer: leading-one detect, mantissa shift, exponent adjust and flags.
// Latency: 2 cycles accepted-input to o_valid, 1 result per cycle when unstalled.
// Backpressure: full; each stage advances when its successor is empty or draining.
module fp_norm_stage
  import fp_norm_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  fp_norm_stage_if.slave   bus
);

  localparam int EW1 = EXP_W + 1;

  logic      s1_vld_q, s1_vld_d;
  norm_s1_t  s1_q, s1_d;
  logic      out_vld_q, out_vld_d;
  norm_out_t out_q, out_d;
  norm_out_t res;

  logic      adv1, adv2;
  logic [SH_W-1:0] lopd_pos;
  logic            lopd_zero;

  logic [EW1-1:0]  exp9;
  logic [EW1-1:0]  exp_inc;
  logic [EW1-1:0]  exp_sub;
  logic [SH_W-1:0] sh;
  logic [SH_W-1:0] ush;

  LOPD_24bit u_lopd (
    .i_data (bus.i_mant[MANT_W-1:0]),
    .o_pos  (lopd_pos),
    .o_zero (lopd_zero)
  );

  // Pipeline advance: a stage moves when the stage after it is free or emptying.
  always_comb begin
    adv2 = ~out_vld_q | bus.i_ready;
    adv1 = ~s1_vld_q | adv2;
  end

  assign bus.o_ready = adv1;

  // Stage-1 next state: capture operand and LOPD result on acceptance.
  always_comb begin
    s1_vld_d = adv1 ? bus.i_valid : s1_vld_q;
    s1_d     = s1_q;
    if (adv1 && bus.i_valid) begin
      s1_d.sign = bus.i_sign;
      s1_d.exp  = bus.i_exp;
      s1_d.mant = bus.i_mant;
      s1_d.pos  = lopd_pos;
      s1_d.zero = lopd_zero;
    end
  end

  // Stage-2 normalization; exponent math is one bit wider so nothing wraps.
  always_comb begin
    res      = '0;
    res.sign = s1_q.sign;
    exp9     = {1'b0, s1_q.exp};
    exp_inc  = exp9 + EW1'(1);
    sh       = SH_W'(23) - s1_q.pos;
    exp_sub  = exp9 - EW1'(sh);
    ush      = '0;
    if (s1_q.exp == EXP_INF) begin
      // Inf/NaN operands pass straight through.
      res.exp  = s1_q.exp;
      res.mant = s1_q.mant[MANT_W-1:0];
    end else if (s1_q.mant[MANT_W]) begin
      // Carry-out: one right shift; the dropped bit feeds rounding.
      res.sticky = s1_q.mant[0];
      if (exp_inc == {1'b0, EXP_INF}) begin
        res.exp      = EXP_INF;
        res.overflow = 1'b1;
      end else begin
        res.exp  = exp_inc[EXP_W-1:0];
        res.mant = s1_q.mant[MANT_W:1];
      end
    end else if (s1_q.zero) begin
      res.zero = 1'b1;
    end else if (exp9 > EW1'(sh)) begin
      res.mant = s1_q.mant[MANT_W-1:0] << sh;
      res.exp  = exp_sub[EXP_W-1:0];
    end else begin
      // Exponent runs out before the leading one reaches the hidden bit:
      // shift only as far as exponent 1 allows and emit a denormal.
      // Here exp <= sh <= 23, so its low SH_W bits carry the full value.
      if (s1_q.exp != '0) ush = s1_q.exp[SH_W-1:0] - SH_W'(1);
      res.mant      = s1_q.mant[MANT_W-1:0] << ush;
      res.underflow = 1'b1;
    end
  end

  // Output next state: load a new result only when stage 1 hands one over.
  always_comb begin
    out_vld_d = adv2 ? s1_vld_q : out_vld_q;
    out_d     = (adv2 && s1_vld_q) ? res : out_q;
  end

  // Pipeline registers with synchronous flush.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_vld_q  <= 1'b0;
      s1_q      <= '0;
      out_vld_q <= 1'b0;
      out_q     <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_q      <= s1_d;
      out_vld_q <= out_vld_d;
      out_q     <= out_d;
    end
  end

  assign bus.o_valid     = out_vld_q;
  assign bus.o_sign      = out_q.sign;
  assign bus.o_exp       = out_q.exp;
  assign bus.o_mant      = out_q.mant;
  assign bus.o_sticky    = out_q.sticky;
  assign bus.o_zero      = out_q.zero;
  assign bus.o_underflow = out_q.underflow;
  assign bus.o_overflow  = out_q.overflow;

endmodule

// File: tb/tb_fp_norm_stage.sv
// Bench for fp_norm_stage: directed corner vectors, backpressure, reset flush, random traffic.
// Latency: checks the 2-cycle fill latency explicitly.
// Backpressure: i_ready driven high, low or randomly by a dedicated process.
module tb_fp_norm_stage;
  import fp_norm_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_norm_stage_if bus ();

  fp_norm_stage dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  logic [36:0] exp_q[$];
  int acc_cnt = 0;
  int emit_cnt = 0;
  int rdy_mode = 0;   // 0: ready high, 1: random, 2: ready low
  bit bp_done = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [36:0] pk(input logic s, input int e, input int m,
                                     input bit st, input bit z, input bit uf, input bit of);
    return {s, 8'(e), 24'(m), st, z, uf, of};
  endfunction

  // Reference: plain integer arithmetic on the normalization rules.
  function automatic logic [36:0] model(input logic s, input int e, input int m);
    int p, sh, rm, re;
    bit st, z, uf, of;
    st = 0; z = 0; uf = 0; of = 0;
    re = e; rm = 0;
    if (e == 255) begin
      rm = m % (1 << 24);
    end else if (m >= (1 << 24)) begin
      st = bit'(m % 2);
      if (e + 1 == 255) begin re = 255; rm = 0; of = 1; end
      else begin re = e + 1; rm = m / 2; end
    end else if (m == 0) begin
      re = 0; z = 1;
    end else begin
      p = 0;
      for (int i = 0; i < 24; i++) if (m >= (1 << i)) p = i;
      sh = 23 - p;
      if (e > sh) begin rm = m * (1 << sh); re = e - sh; end
      else begin rm = m * (1 << ((e == 0) ? 0 : e - 1)); re = 0; uf = 1; end
    end
    return pk(s, re, rm, st, z, uf, of);
  endfunction

  function automatic logic [36:0] dut_out();
    return {bus.o_sign, bus.o_exp, bus.o_mant, bus.o_sticky,
            bus.o_zero, bus.o_underflow, bus.o_overflow};
  endfunction

  // Downstream ready generator, updated just after each rising edge.
  initial begin
    bus.i_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.i_ready = 1'b1;
        1:       bus.i_ready = ($urandom_range(0, 3) != 0);
        default: bus.i_ready = 1'b0;
      endcase
    end
  end

  // Monitor: scoreboard on transfers, stability while stalled.
  initial begin
    bit hold_vld;
    logic [36:0] hold_val;
    hold_vld = 0;
    hold_val = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_vld = 0;
      end else begin
        if (hold_vld) begin
          chk("hold_valid", 64'(bus.o_valid), 64'd1);
          chk("hold_data", 64'(dut_out()), 64'(hold_val));
        end
        if (bus.o_valid && bus.i_ready) begin
          if (exp_q.size() == 0) chk("spurious_out", 64'(bus.o_valid), 64'd0);
          else begin
            chk("result", 64'(dut_out()), 64'(exp_q.pop_front()));
            emit_cnt++;
          end
        end
        hold_vld = bus.o_valid && !bus.i_ready;
        hold_val = dut_out();
      end
    end
  end

  // Offer one operand; expected result is either given or taken from the model.
  task automatic send(input logic s, input int e, input int m,
                      input bit has_xp, input logic [36:0] xp);
    int budget;
    bit ok;
    budget = 0;
    ok = 0;
    bus.i_valid = 1'b1;
    bus.i_sign  = s;
    bus.i_exp   = 8'(e);
    bus.i_mant  = 25'(m);
    while (!ok && budget < 200) begin
      @(negedge clk);
      if (bus.o_ready) ok = 1;
      else budget++;
    end
    if (!ok) begin
      chk("o_ready_timeout", 64'(bus.o_ready), 64'd1);
    end else begin
      @(posedge clk);
      exp_q.push_back(has_xp ? xp : model(s, e, m));
      acc_cnt++;
      #1;
    end
    bus.i_valid = 1'b0;
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 500) begin
      @(negedge clk);
      b++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e0, a0, b;
    logic [36:0] dir_xp [8];
    int dir_e [8];
    int dir_m [8];
    logic dir_s [8];

    dir_s[0] = 0; dir_e[0] = 100; dir_m[0] = 'h0800000; dir_xp[0] = pk(0, 100, 'h800000, 0, 0, 0, 0);
    dir_s[1] = 0; dir_e[1] = 100; dir_m[1] = 'h1000001; dir_xp[1] = pk(0, 101, 'h800000, 1, 0, 0, 0);
    dir_s[2] = 1; dir_e[2] = 254; dir_m[2] = 'h1000001; dir_xp[2] = pk(1, 255, 0, 1, 0, 0, 1);
    dir_s[3] = 0; dir_e[3] = 20;  dir_m[3] = 'h0000100; dir_xp[3] = pk(0, 5, 'h800000, 0, 0, 0, 0);
    dir_s[4] = 0; dir_e[4] = 5;   dir_m[4] = 'h0000100; dir_xp[4] = pk(0, 0, 'h001000, 0, 0, 1, 0);
    dir_s[5] = 0; dir_e[5] = 77;  dir_m[5] = 0;         dir_xp[5] = pk(0, 0, 0, 0, 1, 0, 0);
    dir_s[6] = 1; dir_e[6] = 255; dir_m[6] = 'h1234567; dir_xp[6] = pk(1, 255, 'h234567, 0, 0, 0, 0);
    dir_s[7] = 0; dir_e[7] = 0;   dir_m[7] = 'h0000001; dir_xp[7] = pk(0, 0, 'h000001, 0, 0, 1, 0);

    rst = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_sign  = 1'b0;
    bus.i_exp   = '0;
    bus.i_mant  = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_o_valid", 64'(bus.o_valid), 64'd0);
    chk("rst_outputs", 64'(dut_out()), 64'd0);
    chk("rst_o_ready", 64'(bus.o_ready), 64'd1);
    @(posedge clk); #1;

    // Fill latency on an empty pipe.
    send(dir_s[0], dir_e[0], dir_m[0], 1, dir_xp[0]);
    @(negedge clk);
    chk("lat_cycle1", 64'(bus.o_valid), 64'd0);
    @(negedge clk);
    chk("lat_cycle2", 64'(bus.o_valid), 64'd1);
    @(posedge clk); #1;

    for (int i = 1; i < 8; i++) send(dir_s[i], dir_e[i], dir_m[i], 1, dir_xp[i]);
    drain();

    // Backpressure: four back-to-back offers against a stalled consumer.
    rdy_mode = 2;
    @(posedge clk); #2;
    a0 = acc_cnt;
    e0 = emit_cnt;
    bp_done = 0;
    fork
      begin
        for (int k = 0; k < 4; k++)
          send(1'($urandom_range(0, 1)), $urandom_range(1, 254), int'($urandom_range(1, 'h1FFFFFF)), 0, '0);
        bp_done = 1;
      end
    join_none
    repeat (3) @(negedge clk);
    chk("bp_accepts", 64'(acc_cnt - a0), 64'd2);
    chk("bp_o_ready", 64'(bus.o_ready), 64'd0);
    rdy_mode = 0;
    b = 0;
    while (!bp_done && b < 200) begin @(negedge clk); b++; end
    chk("bp_sender_done", 64'(bp_done), 64'd1);
    drain();
    chk("bp_emitted", 64'(emit_cnt - e0), 64'd4);

    // Reset with two transactions in flight.
    rdy_mode = 2;
    @(posedge clk); #2;
    send(0, 100, 'h0800000, 0, '0);
    send(1, 50, 'h0000F00, 0, '0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_pre_valid", 64'(bus.o_valid), 64'd1);
    @(posedge clk); #1;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_o_valid", 64'(bus.o_valid), 64'd0);
    chk("midrst_outputs", 64'(dut_out()), 64'd0);
    chk("midrst_o_ready", 64'(bus.o_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    rdy_mode = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("postrst_no_stale", 64'(bus.o_valid), 64'd0);
    end
    @(posedge clk); #1;

    // Random traffic with random downstream stalls.
    rdy_mode = 1;
    for (int n = 0; n < 300; n++) begin
      int e, m, w, g;
      g = $urandom_range(0, 3);
      if (g != 0) begin
        repeat (g - 1) @(posedge clk);
        if (g > 1) #1;
      end
      case ($urandom_range(0, 5))
        0: e = 0;
        1: e = 1;
        2: e = 254;
        3: e = 255;
        default: e = $urandom_range(0, 255);
      endcase
      w = $urandom_range(0, 25);
      m = int'($urandom) & ((1 << w) - 1);
      send(1'($urandom_range(0, 1)), e, m, 0, '0);
    end
    rdy_mode = 0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
